// File: rtl/enum_type.sv
// Shared game-control enumerations: command type plus key decoder FSM state and
// the escape-sequence byte constants.
package enum_type;

    typedef enum logic [3:0] {
        NONE,
        LEFT,
        RIGHT,
        DOWN,
        DROP,
        HOLD,
        ROTATE,
        ROTATE_REV,
        BAR
    } state_type;

    typedef enum logic [1:0] {
        K_IDLE,
        K_ESC,
        K_CSI
    } key_fsm_t;

    localparam logic [7:0] ASCII_ESC = 8'h1B;
    localparam logic [7:0] ASCII_CSI = 8'h5B;

endpackage

// File: rtl/key_decoder_key_map.sv
// Pure byte-to-command map: plain single keys, or the final byte of an ANSI
// arrow sequence when is_csi is set. Unknown bytes map to NONE.
module key_map
    import enum_type::*;
(
    input  logic [7:0] key_byte,
    input  logic       is_csi,
    output state_type  key_cmd
);

    always_comb begin
        key_cmd = NONE;
        if (is_csi) begin
            case (key_byte)
                8'h41:   key_cmd = HOLD;
                8'h42:   key_cmd = DOWN;
                8'h43:   key_cmd = RIGHT;
                8'h44:   key_cmd = LEFT;
                default: key_cmd = NONE;
            endcase
        end else begin
            case (key_byte)
                "A", "a":      key_cmd = LEFT;
                "D", "d":      key_cmd = RIGHT;
                "S", "s":      key_cmd = DOWN;
                "W", "w", " ": key_cmd = DROP;
                "C", "c":      key_cmd = HOLD;
                "X", "x":      key_cmd = ROTATE;
                "Z", "z":      key_cmd = ROTATE_REV;
                "B", "b":      key_cmd = BAR;
                default:       key_cmd = NONE;
            endcase
        end
    end

endmodule

// File: rtl/key_decoder.sv
// UART byte stream to one-cycle game command pulses, including ESC '[' X
// arrow sequences guarded by an inter-byte timeout.
module key_decoder
    import enum_type::*;
#(
    parameter int ESC_TIMEOUT = 2_500_000,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rx_valid,
    input  logic [7:0]       rx_byte,
    input  logic             rx_error,
    output logic             cmd_valid,
    output state_type        cmd,
    output logic             seq_busy,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int TW = $clog2(ESC_TIMEOUT) + 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(ESC_TIMEOUT - 1);

    key_fsm_t         fsm_q, fsm_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             cmd_valid_q, cmd_valid_d;
    state_type        cmd_q, cmd_d;
    logic             seq_busy_q, seq_busy_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic             err_inc;
    state_type        mapped;

    key_map u_key_map (
        .key_byte (rx_byte),
        .is_csi   (fsm_q == K_CSI),
        .key_cmd  (mapped)
    );

    always_comb begin
        fsm_d       = fsm_q;
        timer_d     = timer_q;
        cmd_valid_d = 1'b0;
        cmd_d       = NONE;
        err_inc     = 1'b0;

        if (rx_error) begin
            // Framing error wins over everything; any coincident byte is dropped.
            fsm_d   = K_IDLE;
            err_inc = 1'b1;
        end else if (rx_valid) begin
            case (fsm_q)
                K_IDLE: begin
                    if (rx_byte == ASCII_ESC) begin
                        fsm_d   = K_ESC;
                        timer_d = '0;
                    end else if (mapped != NONE) begin
                        cmd_valid_d = 1'b1;
                        cmd_d       = mapped;
                    end
                end
                K_ESC: begin
                    if (rx_byte == ASCII_CSI) begin
                        fsm_d   = K_CSI;
                        timer_d = '0;
                    end else if (rx_byte == ASCII_ESC) begin
                        timer_d = '0;
                    end else begin
                        // Broken sequence, but the byte still counts as a plain key.
                        fsm_d   = K_IDLE;
                        err_inc = 1'b1;
                        if (mapped != NONE) begin
                            cmd_valid_d = 1'b1;
                            cmd_d       = mapped;
                        end
                    end
                end
                K_CSI: begin
                    if (mapped != NONE) begin
                        fsm_d       = K_IDLE;
                        cmd_valid_d = 1'b1;
                        cmd_d       = mapped;
                    end else if (rx_byte == ASCII_ESC) begin
                        fsm_d   = K_ESC;
                        timer_d = '0;
                        err_inc = 1'b1;
                    end else begin
                        fsm_d   = K_IDLE;
                        err_inc = 1'b1;
                    end
                end
                default: fsm_d = K_IDLE;
            endcase
        end else if (fsm_q != K_IDLE) begin
            if (timer_q == TIMER_LAST) begin
                // A lone ESC key is legal; an unfinished CSI is an error.
                fsm_d   = K_IDLE;
                err_inc = (fsm_q == K_CSI);
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end

        if (fsm_d == K_IDLE) begin
            timer_d = '0;
        end

        seq_busy_d = (fsm_d != K_IDLE);
        err_cnt_d  = (err_inc && (err_cnt_q != '1)) ? err_cnt_q + 1'b1 : err_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fsm_q       <= K_IDLE;
            timer_q     <= '0;
            cmd_valid_q <= 1'b0;
            cmd_q       <= NONE;
            seq_busy_q  <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            fsm_q       <= fsm_d;
            timer_q     <= timer_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_q       <= cmd_d;
            seq_busy_q  <= seq_busy_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd       = cmd_q;
    assign seq_busy  = seq_busy_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_key_decoder.sv
// Scoreboard bench for key_decoder: driver queues expected commands with their
// due cycle, a negedge monitor pops and compares every cmd_valid pulse.
module tb_key_decoder;
    import enum_type::*;

    localparam int ESC_TIMEOUT = 1000;
    localparam int ERR_W       = 8;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             rx_valid = 1'b0;
    logic [7:0]       rx_byte = 8'h00;
    logic             rx_error = 1'b0;
    logic             cmd_valid;
    state_type        cmd;
    logic             seq_busy;
    logic [ERR_W-1:0] err_cnt;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        state_type c;
        int        due;
    } exp_t;
    exp_t exp_q[$];

    key_decoder #(.ESC_TIMEOUT(ESC_TIMEOUT), .ERR_W(ERR_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .rx_error  (rx_error),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .seq_busy  (seq_busy),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every pulse must match the head of the queue, on its due cycle.
    always @(negedge clk) begin
        if (reset_n) begin
            if (cmd_valid) begin
                exp_t e;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pulse cyc=%0d cmd=%0d expected no pulse", cyc, cmd);
                end else begin
                    e = exp_q.pop_front();
                    if (cmd !== e.c || cyc != e.due) begin
                        n_fail++;
                        $display("FAIL cmd_pulse got cmd=%0d at cyc %0d, expected cmd=%0d at cyc %0d",
                                 cmd, cyc, e.c, e.due);
                    end
                end
            end else begin
                n_cmp++;
                if (cmd !== NONE) begin
                    n_fail++;
                    $display("FAIL cmd_idle cyc=%0d cmd=%0d expected %0d", cyc, cmd, NONE);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got %0d expected %0d", name, got, want);
        end
    endtask

    // Present one byte for one clock; optionally queue the command it should produce.
    task automatic send(input logic [7:0] b, input state_type want);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        if (want != NONE) exp_q.push_back('{c: want, due: cyc});
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic at_neg;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        at_neg();
        check("reset_cmd_valid", 32'(cmd_valid), 0);
        check("reset_cmd", 32'(cmd), 32'(NONE));
        check("reset_seq_busy", 32'(seq_busy), 0);
        check("reset_err_cnt", 32'(err_cnt), 0);

        // Plain keys
        idle(1);
        send("a", LEFT);  idle(10);
        send("D", RIGHT); idle(10);
        send(" ", DROP);  idle(10);
        send("q", NONE);  idle(3);
        at_neg();
        check("plain_err_cnt", 32'(err_cnt), 0);

        // Full arrow sequence with 100-cycle gaps
        idle(1);
        send(ASCII_ESC, NONE);
        at_neg();
        check("esc_busy", 32'(seq_busy), 1);
        idle(100);
        send(ASCII_CSI, NONE);
        idle(100);
        at_neg();
        check("csi_busy", 32'(seq_busy), 1);
        idle(1);
        send(8'h43, RIGHT);
        at_neg();
        check("arrow_done_busy", 32'(seq_busy), 0);
        check("arrow_err_cnt", 32'(err_cnt), 0);

        // Lone ESC timeout: still busy after 999 idle cycles, idle after 1000
        idle(2);
        send(ASCII_ESC, NONE);
        repeat (ESC_TIMEOUT - 1) @(posedge clk);
        at_neg();
        check("esc_pre_timeout_busy", 32'(seq_busy), 1);
        @(posedge clk);
        at_neg();
        check("esc_timeout_busy", 32'(seq_busy), 0);
        check("esc_timeout_err", 32'(err_cnt), 0);
        idle(1);
        send("s", DOWN);
        idle(3);

        // CSI timeout counts an error; broken ESC still decodes the key
        send(ASCII_ESC, NONE);
        send(ASCII_CSI, NONE);
        idle(ESC_TIMEOUT);
        at_neg();
        check("csi_timeout_err", 32'(err_cnt), 1);
        check("csi_timeout_busy", 32'(seq_busy), 0);
        idle(1);
        send(ASCII_ESC, NONE);
        send("x", ROTATE);
        at_neg();
        check("esc_x_err", 32'(err_cnt), 2);
        check("esc_x_busy", 32'(seq_busy), 0);

        // Repeated ESC restarts the sequence without error
        idle(1);
        send(ASCII_ESC, NONE);
        send(ASCII_ESC, NONE);
        send(ASCII_CSI, NONE);
        send(8'h41, HOLD);
        at_neg();
        check("esc_esc_err", 32'(err_cnt), 2);

        // rx_error beats a coincident final byte
        idle(1);
        send(ASCII_ESC, NONE);
        send(ASCII_CSI, NONE);
        rx_error = 1'b1;
        rx_valid = 1'b1;
        rx_byte  = 8'h41;
        @(posedge clk);
        #1;
        rx_error = 1'b0;
        rx_valid = 1'b0;
        at_neg();
        check("rxerr_err", 32'(err_cnt), 3);
        check("rxerr_busy", 32'(seq_busy), 0);

        // Reset mid-sequence
        idle(1);
        send(ASCII_ESC, NONE);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        at_neg();
        check("midreset_busy", 32'(seq_busy), 0);
        check("midreset_err", 32'(err_cnt), 0);
        check("midreset_cmd_valid", 32'(cmd_valid), 0);
        check("midreset_cmd", 32'(cmd), 32'(NONE));
        idle(1);
        reset_n = 1'b1;
        idle(2);
        send("b", BAR);
        idle(2);

        // Saturation
        for (int i = 0; i < 300; i++) begin
            rx_error = 1'b1;
            @(posedge clk);
            #1;
            rx_error = 1'b0;
            if (i == 254) begin
                at_neg();
                check("err_at_255", 32'(err_cnt), 255);
            end
        end
        at_neg();
        check("err_saturated", 32'(err_cnt), 255);

        idle(5);
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
